arith_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one fixed-latency arithmetic unit (adder or multiplier variant behind `dut_wrapper`) among `NUM_REQ` requesters. It accepts operand pairs through a per-requester valid/ready handshake and issues at most one operation per cycle to the shared unit. It tracks each in-flight operation's requester tag through a latency-matched pipeline and returns each result to the requester that issued it. It sits between client blocks and the shared arithmetic datapath.

---
 rtl/arith_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_arith_share_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/arith_share_arbiter.sv
// arith_share_arbiter: round-robin front end for one shared fixed-latency
// arithmetic unit. It grants one requester per cycle, registers the operands
// toward the unit, and carries the requester tag down a latency-matched
// pipeline so that each result is steered back to the requester that issued it.
module arith_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]          req_a,
  input  logic [NUM_REQ*WIDTH-1:0]          req_b,
  input  logic [NUM_REQ-1:0]                req_op,
  input  logic                              stall,
  output logic                              unit_valid,
  output logic [WIDTH-1:0]                  unit_a,
  output logic [WIDTH-1:0]                  unit_b,
  output logic                              unit_op,
  input  logic [2*WIDTH-1:0]                unit_result,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [2*WIDTH-1:0]                resp_result,
  output logic [$clog2(LATENCY+2)-1:0]      inflight
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] INF_MAX = CNT_W'(LATENCY + 1);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W:0]   pick;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] unit_tag;
  logic [LATENCY-1:0] pipe_valid;
  logic [PTR_W-1:0] pipe_tag [LATENCY];
  logic             tail_valid;

  // First valid requester at or after ptr, wrapping; returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] sel;
    int               idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found && valid[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  assign tail_valid = pipe_valid[LATENCY-1];

  // Combinational round-robin grant; suppressed while stalled or in reset.
  always_comb begin
    pick      = rr_pick(req_valid, rr_ptr);
    grant_idx = pick[PTR_W-1:0];
    if (stall || reset) begin
      grant_any = 1'b0;
    end else begin
      grant_any = pick[PTR_W];
    end
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Pointer advance and issue register toward the shared unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      unit_valid <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
      unit_op    <= 1'b0;
      unit_tag   <= '0;
    end else if (grant_any) begin
      rr_ptr     <= (grant_idx == LAST_REQ) ? '0 : grant_idx + PTR_W'(1);
      unit_valid <= 1'b1;
      unit_a     <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
      unit_b     <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
      unit_op    <= req_op[grant_idx];
      unit_tag   <= grant_idx;
    end else begin
      unit_valid <= 1'b0;
    end
  end

  // Tag pipeline matched to the unit latency; its tail lines up with unit_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= unit_valid;
      pipe_tag[0]   <= unit_tag;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
    end
  end

  // Capture the unit result and pulse the owning requester's response strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid  <= '0;
      resp_result <= '0;
    end else begin
      resp_valid <= '0;
      if (tail_valid) begin
        resp_valid[pipe_tag[LATENCY-1]] <= 1'b1;
        resp_result                     <= unit_result;
      end
    end
  end

  // Count operations issued but not yet answered; the answer counts when it is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({grant_any, tail_valid})
        2'b10: begin
          if (inflight != INF_MAX) begin
            inflight <= inflight + CNT_W'(1);
          end
        end
        2'b01: begin
          if (inflight != '0) begin
            inflight <= inflight - CNT_W'(1);
          end
        end
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_share_arbiter.sv
// Bench for arith_share_arbiter: models the shared unit, predicts grants with
// its own round-robin pointer and scoreboards every expected response.
module tb_arith_share_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 2;
  localparam int CW      = $clog2(LATENCY + 2);

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*WIDTH-1:0]     req_a;
  logic [NUM_REQ*WIDTH-1:0]     req_b;
  logic [NUM_REQ-1:0]           req_op;
  logic                         stall;
  logic                         unit_valid;
  logic [WIDTH-1:0]             unit_a;
  logic [WIDTH-1:0]             unit_b;
  logic                         unit_op;
  logic [2*WIDTH-1:0]           unit_result;
  logic [NUM_REQ-1:0]           resp_valid;
  logic [2*WIDTH-1:0]           resp_result;
  logic [CW-1:0]                inflight;

  arith_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .stall(stall),
    .unit_valid(unit_valid), .unit_a(unit_a), .unit_b(unit_b), .unit_op(unit_op),
    .unit_result(unit_result), .resp_valid(resp_valid), .resp_result(resp_result),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Shared arithmetic unit model: fixed LATENCY from the issue cycle.
  logic [2*WIDTH-1:0] upipe [LATENCY];
  always @(posedge clk) begin
    upipe[0] <= unit_op ? (16'(unit_a) * 16'(unit_b)) : {8'b0, 8'(unit_a + unit_b)};
    for (int i = 1; i < LATENCY; i++) upipe[i] <= upipe[i-1];
  end
  assign unit_result = upipe[LATENCY-1];

  typedef struct {
    int               tag;
    logic [15:0]      res;
    int               due;
  } exp_t;
  exp_t sb[$];

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  int last_g = -1;
  int peak   = 0;
  logic             m_uv  = 1'b0;
  logic [WIDTH-1:0] m_ua  = '0;
  logic [WIDTH-1:0] m_ub  = '0;
  logic             m_uop = 1'b0;
  logic [WIDTH-1:0] opa [NUM_REQ];
  logic [WIDTH-1:0] opb [NUM_REQ];
  logic             opm [NUM_REQ];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_res(input logic [7:0] a, input logic [7:0] b, input logic op);
    logic [7:0] s;
    s = a + b;
    return op ? (16'(a) * 16'(b)) : {8'h00, s};
  endfunction

  // One clock: drive inputs, check grant, advance, then check registered outputs.
  task automatic cycle(input logic [NUM_REQ-1:0] v, input logic s, input logic r);
    int g;
    int idx;
    logic [NUM_REQ-1:0] er;
    exp_t e;
    req_valid = v;
    stall     = s;
    reset     = r;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = opa[i];
      req_b[i*WIDTH +: WIDTH] = opb[i];
      req_op[i]               = opm[i];
    end
    #1;
    g = -1;
    if (!s && !r) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(er));
    last_g = g;
    if (r) begin
      sb.delete();
      m_ptr = 0; m_uv = 1'b0; m_ua = '0; m_ub = '0; m_uop = 1'b0;
    end else if (g >= 0) begin
      e.tag = g;
      e.res = model_res(opa[g], opb[g], opm[g]);
      e.due = cyc + LATENCY + 2;
      sb.push_back(e);
      m_ptr = (g + 1) % NUM_REQ;
      m_uv = 1'b1; m_ua = opa[g]; m_ub = opb[g]; m_uop = opm[g];
    end else begin
      m_uv = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_val("unit_valid", 32'(unit_valid), 32'(m_uv));
    check_val("unit_a", 32'(unit_a), 32'(m_ua));
    check_val("unit_b", 32'(unit_b), 32'(m_ub));
    check_val("unit_op", 32'(unit_op), 32'(m_uop));
    if (r) check_val("resp_result_rst", 32'(resp_result), 32'd0);
    if (resp_valid != '0) begin
      if (sb.size() == 0) begin
        check_val("resp_spurious", 32'(resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        er = '0;
        er[e.tag] = 1'b1;
        check_val("resp_tag", 32'(resp_valid), 32'(er));
        check_val("resp_data", 32'(resp_result), 32'(e.res));
        check_val("resp_time", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      er = '0;
      er[e.tag] = 1'b1;
      check_val("resp_missing", 32'(resp_valid), 32'(er));
    end
    check_val("inflight", 32'(inflight), 32'(sb.size()));
    if (int'(inflight) > peak) peak = int'(inflight);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0);
  endtask

  initial begin
    req_valid = '0; stall = 1'b0; reset = 1'b1; req_a = '0; req_b = '0; req_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin opa[i] = '0; opb[i] = '0; opm[i] = 1'b0; end

    // Reset, then a single add from requester 1.
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    opa[1] = 8'd5; opb[1] = 8'd3; opm[1] = 1'b0;
    cycle(4'b0010, 1'b0, 1'b0);
    idle(6);

    // Round robin with all requesters multiplying; requester 2 starts at 255*255.
    cycle('0, 1'b0, 1'b1);
    for (int i = 0; i < NUM_REQ; i++) begin
      opa[i] = 8'($urandom_range(0, 255)); opb[i] = 8'($urandom_range(0, 255)); opm[i] = 1'b1;
    end
    opa[2] = 8'd255; opb[2] = 8'd255;
    for (int n = 0; n < 10; n++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      if (last_g >= 0) begin
        opa[last_g] = 8'($urandom_range(0, 255));
        opb[last_g] = 8'($urandom_range(0, 255));
      end
    end
    idle(6);

    // Add wrap-around, then 128*128.
    opa[0] = 8'd255; opb[0] = 8'd1; opm[0] = 1'b0;
    cycle(4'b0001, 1'b0, 1'b0);
    opa[0] = 8'd128; opb[0] = 8'd128; opm[0] = 1'b1;
    cycle(4'b0001, 1'b0, 1'b0);
    idle(6);

    // Stall with requesters 0 and 3 pending and two operations in flight.
    opa[0] = 8'd17; opb[0] = 8'd4; opm[0] = 1'b0;
    opa[3] = 8'd9;  opb[3] = 8'd11; opm[3] = 1'b1;
    cycle(4'b1001, 1'b0, 1'b0);
    if (last_g >= 0) begin opa[last_g] = 8'd200; opb[last_g] = 8'd100; end
    cycle(4'b1001, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) cycle(4'b1001, 1'b1, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);
    idle(6);

    // Reset right after three back-to-back issues; nothing may come back.
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1);
    opa[0] = 8'd7; opb[0] = 8'd6; opm[0] = 1'b1;
    opa[2] = 8'd40; opb[2] = 8'd2; opm[2] = 1'b0;
    cycle(4'b0101, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    idle(6);

    // Pointer hold: requester 3 alone three times, then 0 and 3 together.
    cycle('0, 1'b0, 1'b1);
    peak = 0;
    opa[3] = 8'd3; opb[3] = 8'd3; opm[3] = 1'b0;
    opa[0] = 8'd12; opb[0] = 8'd12; opm[0] = 1'b1;
    for (int n = 0; n < 3; n++) cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);
    idle(6);
    check_val("inflight_peak", 32'(peak), 32'(LATENCY + 1));
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
